rr_onehot_arbiter: RTL and testbench

//   Round-robin arbiter directly upstream of the 8-to-3 encoder. Takes 8 request lines and

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_onehot_arbiter_if.sv | 25 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/rr_onehot_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: request count,
// FSM state encoding and the one-hot legality helper.
package arb_pkg;

  localparam int unsigned N_REQ = 32'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // True when v is all-zero or has exactly one bit set.
  function automatic logic onehot_ok(input logic [7:0] v);
    return ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the encoder.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_onehot_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             ack;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic             timeout;
`ifdef ARB_LOCK_EN
  logic             lock;

  modport master (output req, output ack, output lock,
                  input gnt, input gnt_valid, input timeout);
  modport slave  (input req, input ack, input lock,
                  output gnt, output gnt_valid, output timeout);
`else
  modport master (output req, output ack,
                  input gnt, input gnt_valid, input timeout);
  modport slave  (input req, input ack,
                  output gnt, output gnt_valid, output timeout);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so the search starts at
// ptr+1, take the lowest set bit, then map the offset back to a requester.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [2:0]       pick_idx,
  output logic             any
);

  logic [2:0]       start_s;
  logic [N_REQ-1:0] rot_s;
  logic [2:0]       off_s;

  // Rotate, priority-find, rotate back.
  always_comb begin
    start_s = ptr + 3'd1;
    rot_s   = 8'd0;
    off_s   = 3'd0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      rot_s[i] = req[start_s + 3'(i)];
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = 3'(i);
      end else begin
        off_s = off_s;
      end
    end
    any      = |req;
    pick_idx = start_s + off_s;
    if (any) begin
      pick_oh = 8'd1 << pick_idx;
    end else begin
      pick_oh = 8'd0;
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, held until ack or timeout.
// Define ARB_LOCK_EN to add the burst-lock input.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32'd15
) (
  input  logic               clk,
  input  logic               rst,
  rr_onehot_arbiter_if.slave bus
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC == 32'd0) ? 32'd1 : $clog2(TIMEOUT_CYC + 32'd1);
  localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((TIMEOUT_CYC == 32'd0) ? 32'd0 : TIMEOUT_CYC - 32'd1);

  arb_state_e       state_r, state_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [2:0]       idx_r, idx_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic             gnt_valid_r;
  logic             timeout_r, timeout_s;
  logic [TMR_W-1:0] tmr_r, tmr_s;
  logic [N_REQ-1:0] pick_oh_s;
  logic [2:0]       pick_idx_s;
  logic             pick_any_s;
  logic             ack_take_s;
  logic             tmo_fire_s;
  logic             lock_s;

  rr_pick u_pick (
    .req      (bus.req),
    .ptr      (ptr_r),
    .pick_oh  (pick_oh_s),
    .pick_idx (pick_idx_s),
    .any      (pick_any_s)
  );

`ifdef ARB_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  // Ack beats a coinciding timeout.
  assign ack_take_s = (state_r == GRANT) && bus.ack;
  assign tmo_fire_s = (TIMEOUT_CYC != 32'd0) && (state_r == GRANT) && !bus.ack
                      && (tmr_r == TMR_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = pick_any_s ? GRANT : IDLE;
      GRANT:   state_s = (ack_take_s || tmo_fire_s) ? IDLE : GRANT;
      default: state_s = IDLE;
    endcase
  end

  // Next values of grant, pointer, timer and timeout pulse.
  always_comb begin
    gnt_s     = gnt_r;
    idx_s     = idx_r;
    ptr_s     = ptr_r;
    tmr_s     = tmr_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        tmr_s = {TMR_W{1'b0}};
        if (pick_any_s) begin
          gnt_s = pick_oh_s;
          idx_s = pick_idx_s;
        end else begin
          gnt_s = 8'd0;
        end
      end
      GRANT: begin
        if (ack_take_s) begin
          gnt_s = 8'd0;
          tmr_s = {TMR_W{1'b0}};
          // Locking parks ptr one behind the winner so it is searched first.
          ptr_s = lock_s ? (idx_r - 3'd1) : idx_r;
        end else if (tmo_fire_s) begin
          gnt_s     = 8'd0;
          tmr_s     = {TMR_W{1'b0}};
          timeout_s = 1'b1;
          ptr_s     = idx_r;
        end else begin
          tmr_s = (tmr_r == {TMR_W{1'b1}}) ? tmr_r : tmr_r + TMR_W'(32'd1);
        end
      end
      default: begin
        gnt_s = 8'd0;
        tmr_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers; gnt_valid tracks |gnt by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r       <= 8'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      ptr_r       <= 3'd7;
      idx_r       <= 3'd0;
      tmr_r       <= {TMR_W{1'b0}};
    end else begin
      gnt_r       <= gnt_s;
      gnt_valid_r <= |gnt_s;
      timeout_r   <= timeout_s;
      ptr_r       <= ptr_s;
      idx_r       <= idx_s;
      tmr_r       <= tmr_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter (TIMEOUT_CYC=4).
// Lock scenario is exercised when ARB_LOCK_EN is defined.
module tb_rr_onehot_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rr_onehot_arbiter_if bus_if ();

  rr_onehot_arbiter #(.TIMEOUT_CYC(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (!onehot_ok(bus_if.gnt) || (bus_if.gnt_valid !== (|bus_if.gnt))) begin
        n_fail++;
        $display("FAIL invariant: gnt=%h gnt_valid=%b", bus_if.gnt, bus_if.gnt_valid);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; bus_if.req = 8'd0; bus_if.ack = 1'b0;
`ifdef ARB_LOCK_EN
    bus_if.lock = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (bus_if.gnt !== 8'd0 || bus_if.gnt_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: gnt=%h valid=%b timeout=%b, want 00/0/0",
               bus_if.gnt, bus_if.gnt_valid, bus_if.timeout);
    end
  endtask

  task automatic test_basic();
    bus_if.req = 8'h81;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h01 || bus_if.gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_first: gnt=%h valid=%b, want 01/1", bus_if.gnt, bus_if.gnt_valid);
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    n_tests++;
    if (bus_if.gnt !== 8'h00) begin
      n_fail++; $display("FAIL basic_ack: gnt=%h, want 00", bus_if.gnt);
    end
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h80) begin
      n_fail++; $display("FAIL basic_second: gnt=%h, want 80", bus_if.gnt);
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0; bus_if.req = 8'd0;
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] exp_seq [9];
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bus_if.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_tests++;
      if (bus_if.gnt !== exp_seq[k]) begin
        n_fail++; $display("FAIL sweep_grant[%0d]: gnt=%h, want %h", k, bus_if.gnt, exp_seq[k]);
      end
      bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
      n_tests++;
      if (bus_if.gnt !== 8'h00) begin
        n_fail++; $display("FAIL sweep_idle[%0d]: gnt=%h, want 00", k, bus_if.gnt);
      end
    end
    bus_if.req = 8'd0;
    tick();
  endtask

  task automatic test_drop_req();
    bus_if.req = 8'h10;
    tick();
    bus_if.req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus_if.gnt !== 8'h10) begin
        n_fail++; $display("FAIL drop_hold[%0d]: gnt=%h, want 10", k, bus_if.gnt);
      end
      if (k < 2) tick();
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    n_tests++;
    if (bus_if.gnt !== 8'h00) begin
      n_fail++; $display("FAIL drop_ack: gnt=%h, want 00", bus_if.gnt);
    end
  endtask

  task automatic test_timeout();
    bus_if.req = 8'h0C;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (bus_if.gnt !== 8'h04 || bus_if.timeout !== 1'b0) begin
        n_fail++; $display("FAIL tmo_hold[%0d]: gnt=%h timeout=%b, want 04/0", k, bus_if.gnt, bus_if.timeout);
      end
    end
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h00 || bus_if.timeout !== 1'b1 || bus_if.gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_fire: gnt=%h timeout=%b valid=%b, want 00/1/0",
                         bus_if.gnt, bus_if.timeout, bus_if.gnt_valid);
    end
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h08 || bus_if.timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_next: gnt=%h timeout=%b, want 08/0", bus_if.gnt, bus_if.timeout);
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0; bus_if.req = 8'd0;
    tick();
  endtask

  task automatic test_ack_at_timeout();
    bus_if.req = 8'h01;
    tick(); tick(); tick(); tick();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0; bus_if.req = 8'd0;
    n_tests++;
    if (bus_if.gnt !== 8'h00 || bus_if.timeout !== 1'b0) begin
      n_fail++; $display("FAIL ack_vs_tmo: gnt=%h timeout=%b, want 00/0", bus_if.gnt, bus_if.timeout);
    end
    tick();
    n_tests++;
    if (bus_if.timeout !== 1'b0) begin
      n_fail++; $display("FAIL ack_vs_tmo_after: timeout=%b, want 0", bus_if.timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    bus_if.req = 8'h40;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h40) begin
      n_fail++; $display("FAIL rstmid_pre: gnt=%h, want 40", bus_if.gnt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if (bus_if.gnt !== 8'h00 || bus_if.gnt_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
      n_fail++; $display("FAIL rstmid: gnt=%h valid=%b timeout=%b, want 00/0/0",
                         bus_if.gnt, bus_if.gnt_valid, bus_if.timeout);
    end
    bus_if.req = 8'h41;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h01) begin
      n_fail++; $display("FAIL rstmid_ptr: gnt=%h, want 01", bus_if.gnt);
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0; bus_if.req = 8'd0;
    tick();
  endtask

  task automatic test_lock();
    bus_if.req = 8'h06;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h02) begin
      n_fail++; $display("FAIL lock_first: gnt=%h, want 02", bus_if.gnt);
    end
`ifdef ARB_LOCK_EN
    bus_if.ack = 1'b1; bus_if.lock = 1'b1; tick(); bus_if.ack = 1'b0; bus_if.lock = 1'b0;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h02) begin
      n_fail++; $display("FAIL lock_regrant: gnt=%h, want 02", bus_if.gnt);
    end
`endif
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    tick();
    n_tests++;
    if (bus_if.gnt !== 8'h04) begin
      n_fail++; $display("FAIL lock_release: gnt=%h, want 04", bus_if.gnt);
    end
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0; bus_if.req = 8'd0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_sweep();
    test_drop_req();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_grant();
    test_lock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
